timestamp_capture: RTL
======================

TIMESTAMP_CAPTURE -- requirements
Module: timestamp_capture

Interface
REQ-001 Parameter CNT_W, default 16: width of the upstream free-running counter value.
REQ-002 Parameter EPOCH_W, default 8: width of the overflow (epoch) counter.
REQ-003 Parameter DEPTH, default 4: timestamp FIFO entries; power of two, >=2.
REQ-004 clk  input  1  sole clock; all logic rising-edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 count  input  CNT_W  upstream counter value, sampled each clk.
REQ-007 overflow  input  1  high in the cycle count is at all-ones; the counter wraps to 0 next cycle.
REQ-008 evt_in  input  1  event strobe, synchronous to clk; rising edge = capture request.
REQ-009 ts_valid  output  1  FIFO head holds a timestamp.
REQ-010 ts_ready  input  1  consumer accepts head when ts_valid&ts_ready.
REQ-011 ts_data  output  EPOCH_W+CNT_W  {epoch, count} of head entry.
REQ-012 fifo_full  output  1  FIFO holds DEPTH entries.
REQ-013 drop_cnt  output  8  events lost to a full FIFO, saturating.

Function
REQ-014 The block shall register evt_in each cycle; edge = evt_in & ~evt_in_q; a level held high shall produce one capture only.
REQ-015 The epoch counter shall increment by 1 at the end of every cycle with overflow=1, wrapping modulo 2^EPOCH_W with no flag.
REQ-016 An edge in cycle t shall capture {epoch_t, count_t}, the values present in cycle t, before any epoch increment caused by overflow in t.
REQ-017 The FIFO shall be first-word-fall-through: ts_data shall equal the head whenever ts_valid=1 and shall hold stable until popped.
REQ-018 Latency: an edge in cycle t into an empty FIFO shall give ts_valid=1 in cycle t+1.
REQ-019 Pop shall occur when ts_valid&ts_ready; ts_ready with ts_valid=0 shall have no effect.
REQ-020 Push shall occur on edge when not full, or when full with a pop in the same cycle (occupancy unchanged).
REQ-021 Edge with full FIFO and no pop shall discard the event and increment drop_cnt, saturating at 255.
REQ-022 Push and pop on an empty FIFO in the same cycle shall not occur (ts_valid=0); the push shall complete normally.
REQ-023 Order shall be strict FIFO; no entry is reordered, duplicated or overwritten.
REQ-024 ts_valid, fifo_full shall be registered-state-derived (no combinational path from evt_in or ts_ready).

Reset
REQ-025 While rst_n=0 at a clk edge: epoch=0, evt_in_q=0, FIFO empty, drop_cnt=0, ts_valid=0, fifo_full=0, ts_data=0.
REQ-026 Reset mid-operation shall discard all queued entries; no pop or push shall occur in a reset cycle.
REQ-027 evt_in high in the first cycle after reset release shall count as an edge.

Structure
REQ-028 Package timestamp_pkg shall hold default CNT_W, EPOCH_W, DEPTH, drop counter width (8) and its saturation value.
REQ-029 The FIFO shall be a sub-module sync_fifo (params WIDTH, DEPTH; push/pop/full/empty, head out), same clk/rst_n.
REQ-030 Epoch counter, edge detect and drop counter shall reside in timestamp_capture.

Verification (CNT_W=4, EPOCH_W=4, DEPTH=4 unless noted)
REQ-031 Single pulse on evt_in at count=5, epoch=0, ts_ready=1 -> ts_valid one cycle later, ts_data=0x05.
REQ-032 Edge coincident with overflow (count=0xF, epoch=2) -> ts_data=0x2F; next edge at count=0 -> 0x30.
REQ-033 evt_in held high 10 cycles -> exactly one entry.
REQ-034 ts_ready=0, 6 separate edges -> 4 entries in capture order, fifo_full=1, drop_cnt=2; then drain -> 4 pops in order, fifo_full=0.
REQ-035 FIFO full, edge with ts_ready=1 same cycle -> drop_cnt unchanged, new entry at tail, occupancy 4.
REQ-036 3 entries queued, rst_n=0 one cycle -> ts_valid=0, drop_cnt=0, epoch=0; 300 drops with ts_ready=0 -> drop_cnt=255.

Source files
------------

// File: rtl/timestamp_pkg.sv
// Shared defaults and helpers for the timestamp capture block.
//   DEF_CNT_W   : default upstream counter width
//   DEF_EPOCH_W : default overflow (epoch) counter width
//   DEF_DEPTH   : default timestamp FIFO depth (power of two, >= 2)
//   DROP_W      : width of the dropped-event counter
//   DROP_MAX    : value at which the dropped-event counter saturates
package timestamp_pkg;

  localparam int unsigned DEF_CNT_W   = 16;
  localparam int unsigned DEF_EPOCH_W = 8;
  localparam int unsigned DEF_DEPTH   = 4;
  localparam int unsigned DROP_W      = 8;

  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

  // Increment that sticks at DROP_MAX instead of wrapping.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == DROP_MAX) ? v : v + DROP_W'(1);
  endfunction

endpackage : timestamp_pkg

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered head.
//   clk, rst_n : clock, synchronous active-low reset
//   push       : write request (ignored when full unless a pop happens too)
//   push_data  : entry to write
//   pop        : read request (ignored when empty)
//   full       : DEPTH entries held (registered)
//   empty      : no entries held (registered)
//   head       : oldest entry, valid while empty=0 (registered, 0 after reset)
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr_inc;
  logic [LVL_W-1:0] level;
  logic [LVL_W-1:0] level_nxt;
  logic [WIDTH-1:0] head_nxt;
  logic             do_push;
  logic             do_pop;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  always_comb begin
    do_pop     = pop & ~empty;
    do_push    = push & (~full | do_pop);
    rd_ptr_inc = rd_ptr + PTR_W'(1);
  end

  // Occupancy after this cycle.
  always_comb begin
    level_nxt = level;
    case ({do_push, do_pop})
      2'b10:   level_nxt = level + LVL_W'(1);
      2'b01:   level_nxt = level - LVL_W'(1);
      default: level_nxt = level;
    endcase
  end

  // Head after this cycle: next stored entry on pop, or the incoming word
  // when it becomes the only entry.
  always_comb begin
    head_nxt = head;
    if (do_pop) begin
      if (level > LVL_W'(1)) begin
        head_nxt = mem[rd_ptr_inc];
      end else if (do_push) begin
        head_nxt = push_data;
      end
    end else if (empty && do_push) begin
      head_nxt = push_data;
    end
  end

  // Storage array; contents are only observed through head, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy, flags and head register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      head   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr_inc;
      end
      level <= level_nxt;
      full  <= (level_nxt == LVL_W'(DEPTH));
      empty <= (level_nxt == '0);
      head  <= head_nxt;
    end
  end

endmodule : sync_fifo

// File: rtl/timestamp_capture.sv
// Captures {epoch, count} on each rising edge of evt_in into a FWFT FIFO.
//   clk, rst_n : clock, synchronous active-low reset
//   count      : upstream free-running counter value
//   overflow   : high while count is all-ones (counter wraps next cycle)
//   evt_in     : event strobe; a rising edge requests one capture
//   ts_valid   : FIFO head holds a timestamp
//   ts_ready   : consumer takes the head when ts_valid & ts_ready
//   ts_data    : {epoch, count} of the head entry
//   fifo_full  : FIFO holds DEPTH entries
//   drop_cnt   : events lost to a full FIFO, saturating
module timestamp_capture
  import timestamp_pkg::*;
#(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned EPOCH_W = DEF_EPOCH_W,
  parameter int unsigned DEPTH   = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CNT_W-1:0]         count,
  input  logic                     overflow,
  input  logic                     evt_in,
  output logic                     ts_valid,
  input  logic                     ts_ready,
  output logic [EPOCH_W+CNT_W-1:0] ts_data,
  output logic                     fifo_full,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam int unsigned TS_W = EPOCH_W + CNT_W;

  logic               evt_q;
  logic               evt_edge;
  logic [EPOCH_W-1:0] epoch;
  logic [TS_W-1:0]    capture;
  logic               fifo_empty;
  logic               fifo_pop;
  logic               drop;

  // Capture uses the epoch held this cycle, before any overflow increment.
  always_comb begin
    evt_edge = evt_in & ~evt_q;
    capture  = {epoch, count};
    fifo_pop = ~fifo_empty & ts_ready;
    drop     = evt_edge & fifo_full & ~fifo_pop;
  end

  // Edge detector history; cleared by reset so a high level right after
  // release is seen as a new event.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      evt_q <= 1'b0;
    end else begin
      evt_q <= evt_in;
    end
  end

  // Epoch advances once per counter wrap, wrapping silently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      epoch <= '0;
    end else if (overflow) begin
      epoch <= epoch + EPOCH_W'(1);
    end
  end

  // Lost-event counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop) begin
      drop_cnt <= sat_inc(drop_cnt);
    end
  end

  sync_fifo #(
    .WIDTH (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (evt_edge),
    .push_data (capture),
    .pop       (ts_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (ts_data)
  );

  assign ts_valid = ~fifo_empty;

endmodule : timestamp_capture
